// File: rtl/demux_ctrl_pkg.sv
// Shared types and constants for the 1-to-4 demux dispatch controller.
// Imported by the controller top and its free-slot picker.
package demux_ctrl_pkg;

  localparam int N_CH  = 4;
  localparam int IDX_W = 2;

  localparam logic MODE_RR  = 1'b0;
  localparam logic MODE_DIR = 1'b1;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/rr_free_pick.sv
// Rotating-priority search for the first free slot starting at ptr.
// Purely combinational; any_o flags that at least one slot is free.
module rr_free_pick
  import demux_ctrl_pkg::*;
(
  input  logic [N_CH-1:0]  free_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [IDX_W-1:0] cand;

  // Scan from farthest offset down so the nearest free slot wins
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int k = N_CH-1; k >= 0; k--) begin
      cand = ptr_i + IDX_W'(k);
      if (free_i[cand]) begin
        idx_o = cand;
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_dispatch_ctrl.sv
// Sequencer for a 1-to-4 demux with one holding slot per channel.
// Round-robin or tag-directed routing, plus a flush/quiesce handshake.
module demux_dispatch_ctrl
  import demux_ctrl_pkg::*;
#(
  parameter int W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              in_valid,
  input  logic [W-1:0]      in_data,
  input  logic [IDX_W-1:0]  in_dest,
  output logic              in_ready,
  output logic [N_CH-1:0]   out_valid,
  output logic [N_CH*W-1:0] out_data,
  input  logic [N_CH-1:0]   out_ready,
  output logic [IDX_W-1:0]  sel,
  input  logic              flush_req,
  output logic              flush_done,
  output logic [15:0]       acc_cnt
);

  state_e                 state_q;
  logic [N_CH-1:0]        slot_v_q;
  logic [N_CH-1:0]        slot_v_d;
  logic [N_CH-1:0][W-1:0] slot_d_q;
  logic [N_CH-1:0]        load_en;
  logic [N_CH-1:0]        drain;
  logic [IDX_W-1:0]       ptr_q;
  logic [IDX_W-1:0]       sel_q;
  logic [IDX_W-1:0]       rr_idx;
  logic [IDX_W-1:0]       tgt;
  logic                   rr_any;
  logic [15:0]            acc_cnt_q;
  logic                   flush_done_q;
  logic                   accept;

  rr_free_pick u_pick (
    .free_i (~slot_v_q),
    .ptr_i  (ptr_q),
    .idx_o  (rr_idx),
    .any_o  (rr_any)
  );

  // Target channel and ready, from registered slot state only
  always_comb begin
    tgt      = (mode == MODE_DIR) ? in_dest : rr_idx;
    in_ready = 1'b0;
    if (!rst && state_q == RUN && !flush_req) begin
      in_ready = (mode == MODE_RR) ? rr_any
                                   : !slot_v_q[in_dest];
    end
  end

  assign accept = in_valid & in_ready;

  // Demux the load strobe to slot enables; compute next occupancy
  always_comb begin
    load_en      = '0;
    load_en[tgt] = accept;
    drain        = slot_v_q & out_ready;
    slot_v_d     = (slot_v_q & ~drain) | load_en;
  end

  // Holding slots: fill on load, clear on consumer handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_v_q <= '0;
      slot_d_q <= '0;
    end else begin
      slot_v_q <= slot_v_d;
      for (int c = 0; c < N_CH; c++) begin
        if (load_en[c]) slot_d_q[c] <= in_data;
      end
    end
  end

  // Control FSM with registered pointer, select, count and done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      ptr_q        <= '0;
      sel_q        <= '0;
      acc_cnt_q    <= '0;
      flush_done_q <= 1'b0;
    end else begin
      flush_done_q <= 1'b0;
      unique case (state_q)
        RUN: begin
          if (flush_req) begin
            state_q <= FLUSH;
          end else if (accept) begin
            sel_q     <= tgt;
            acc_cnt_q <= acc_cnt_q + 16'd1;
            if (mode == MODE_RR) ptr_q <= tgt + 1'b1;
          end
        end
        FLUSH: begin
          if (slot_v_d == '0) begin
            state_q      <= DONE;
            flush_done_q <= 1'b1;
          end
        end
        DONE: begin
          ptr_q   <= '0;
          sel_q   <= '0;
          state_q <= flush_req ? FLUSH : RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign out_valid  = slot_v_q;
  assign out_data   = slot_d_q;
  assign sel        = sel_q;
  assign acc_cnt    = acc_cnt_q;
  assign flush_done = flush_done_q;

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Self-checking bench for demux_dispatch_ctrl.
// Directed scenarios plus randomized traffic against a slot-level model.
module tb_demux_dispatch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic        in_valid;
  logic [7:0]  in_data;
  logic [1:0]  in_dest;
  logic        in_ready;
  logic [3:0]  out_valid;
  logic [31:0] out_data;
  logic [3:0]  out_ready;
  logic [1:0]  sel;
  logic        flush_req;
  logic        flush_done;
  logic [15:0] acc_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: which slots hold what, where the next search starts
  logic [3:0] m_v;
  logic [7:0] m_d [4];
  int         m_ptr;
  int         m_sel;
  int         m_cnt;
  bit         m_flushing;
  bit         m_done;

  always #5 clk = ~clk;

  demux_dispatch_ctrl #(.W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_dest    (in_dest),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .sel        (sel),
    .flush_req  (flush_req),
    .flush_done (flush_done),
    .acc_cnt    (acc_cnt)
  );

  function automatic logic [31:0] m_data();
    return {m_d[3], m_d[2], m_d[1], m_d[0]};
  endfunction

  function automatic bit m_ready();
    if (rst || m_flushing || m_done || flush_req) return 1'b0;
    if (mode) return !m_v[in_dest];
    return m_v != 4'hF;
  endfunction

  function automatic int m_target();
    if (mode) return int'(in_dest);
    for (int k = 0; k < 4; k++)
      if (!m_v[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    return 0;
  endfunction

  task automatic m_reset();
    m_v = '0;
    for (int c = 0; c < 4; c++) m_d[c] = '0;
    m_ptr = 0;
    m_sel = 0;
    m_cnt = 0;
    m_flushing = 1'b0;
    m_done = 1'b0;
  endtask

  // Advance one clock; model follows the word-level rules
  task automatic tick();
    bit         acc;
    int         tgt;
    logic [3:0] drn;
    logic [7:0] dat;
    bit         md;
    bit         fr;
    acc = in_valid && m_ready();
    tgt = m_target();
    drn = m_v & out_ready;
    dat = in_data;
    md  = mode;
    fr  = flush_req;
    @(posedge clk);
    if (rst) begin
      m_reset();
    end else begin
      m_v = m_v & ~drn;
      if (m_done) begin
        m_done = 1'b0;
        m_ptr = 0;
        m_sel = 0;
        m_flushing = fr;
      end else if (m_flushing) begin
        if (m_v == 4'h0) begin
          m_flushing = 1'b0;
          m_done = 1'b1;
        end
      end else if (fr) begin
        m_flushing = 1'b1;
      end else if (acc) begin
        m_v[tgt] = 1'b1;
        m_d[tgt] = dat;
        m_sel = tgt;
        m_cnt = (m_cnt + 1) % 65536;
        if (!md) m_ptr = (tgt + 1) % 4;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mode = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h5A;
    in_dest = 2'd0;
    out_ready = 4'h0;
    flush_req = 1'b0;
    m_reset();
    repeat (2) tick();
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready got %b exp 0", in_ready);
    end
    checks++;
    if (out_valid !== 4'h0 || out_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_out got v=%h d=%h exp 0/0", out_valid, out_data);
    end
    checks++;
    if (sel !== 2'd0 || acc_cnt !== 16'd0 || flush_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs got sel=%0d cnt=%0d fd=%b exp 0/0/0",
               sel, acc_cnt, flush_done);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_rr_fill();
    logic [7:0] words [5];
    bit exp_rdy;
    words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    mode = 1'b0;
    out_ready = 4'h0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data = words[i];
      #1;
      exp_rdy = (i < 4);
      checks++;
      if (in_ready !== exp_rdy || in_ready !== m_ready()) begin
        errors++;
        $display("FAIL rr_ready[%0d] got %b exp %b", i, in_ready, exp_rdy);
      end
      tick();
      if (i < 4) begin
        checks++;
        if (sel !== 2'(i)) begin
          errors++;
          $display("FAIL rr_sel[%0d] got %0d exp %0d", i, sel, i);
        end
      end
    end
    checks++;
    if (out_data !== 32'h44332211 || out_valid !== 4'hF) begin
      errors++;
      $display("FAIL rr_slots got v=%h d=%h exp f/44332211",
               out_valid, out_data);
    end
    checks++;
    if (acc_cnt !== 16'd4 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rr_cnt got cnt=%0d rdy=%b exp 4/0", acc_cnt, in_ready);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_skip_occupied();
    in_valid = 1'b0;
    out_ready = 4'b1101;
    #1;
    tick();
    out_ready = 4'h0;
    in_valid = 1'b1;
    in_data = 8'hC3;
    #1;
    tick();
    in_data = 8'hA5;
    #1;
    tick();
    checks++;
    if (sel !== 2'd2 || out_data[23:16] !== 8'hA5) begin
      errors++;
      $display("FAIL skip_occ got sel=%0d d2=%h exp 2/a5",
               sel, out_data[23:16]);
    end
    checks++;
    if (out_valid !== 4'b0111 || out_data !== m_data()) begin
      errors++;
      $display("FAIL skip_slots got v=%h d=%h exp 7/%h",
               out_valid, out_data, m_data());
    end
    in_data = 8'h3C;
    #1;
    tick();
    checks++;
    if (sel !== 2'd3 || out_data[31:24] !== 8'h3C) begin
      errors++;
      $display("FAIL skip_ptr3 got sel=%0d d3=%h exp 3/3c",
               sel, out_data[31:24]);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_directed();
    mode = 1'b1;
    in_dest = 2'd3;
    in_data = 8'h7E;
    in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL dir_full_ready got %b exp 0", in_ready);
    end
    out_ready = 4'b1000;
    tick();
    out_ready = 4'h0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid[3] !== 1'b0) begin
      errors++;
      $display("FAIL dir_freed got rdy=%b v3=%b exp 1/0",
               in_ready, out_valid[3]);
    end
    tick();
    checks++;
    if (out_data[31:24] !== 8'h7E || sel !== 2'd3 || out_valid[3] !== 1'b1) begin
      errors++;
      $display("FAIL dir_accept got d3=%h sel=%0d v3=%b exp 7e/3/1",
               out_data[31:24], sel, out_valid[3]);
    end
    checks++;
    if (acc_cnt !== 16'(m_cnt)) begin
      errors++;
      $display("FAIL dir_cnt got %0d exp %0d", acc_cnt, m_cnt);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_flush();
    mode = 1'b0;
    in_valid = 1'b0;
    out_ready = 4'hF;
    #1;
    tick();
    out_ready = 4'h0;
    in_valid = 1'b1;
    in_data = 8'h91;
    #1;
    tick();
    in_data = 8'h92;
    #1;
    tick();
    flush_req = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready got %b exp 0", in_ready);
    end
    tick();
    tick();
    checks++;
    if (flush_done !== 1'b0 || out_valid !== m_v || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_hold got fd=%b v=%h rdy=%b exp 0/%h/0",
               flush_done, out_valid, in_ready, m_v);
    end
    out_ready = 4'hF;
    tick();
    out_ready = 4'h0;
    #1;
    checks++;
    if (flush_done !== 1'b1 || !m_done) begin
      errors++;
      $display("FAIL flush_done got %b exp 1", flush_done);
    end
    flush_req = 1'b0;
    in_valid = 1'b0;
    tick();
    checks++;
    if (flush_done !== 1'b0 || sel !== 2'd0 || acc_cnt !== 16'(m_cnt)) begin
      errors++;
      $display("FAIL flush_after got fd=%b sel=%0d cnt=%0d exp 0/0/%0d",
               flush_done, sel, acc_cnt, m_cnt);
    end
    in_valid = 1'b1;
    in_data = 8'hB7;
    #1;
    tick();
    checks++;
    if (sel !== 2'd0 || out_valid !== 4'b0001 || out_data[7:0] !== 8'hB7) begin
      errors++;
      $display("FAIL flush_ptr0 got sel=%0d v=%h d0=%h exp 0/1/b7",
               sel, out_valid, out_data[7:0]);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    mode = 1'b0;
    out_ready = 4'h0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'($urandom);
      #1;
      tick();
    end
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 4'h0 || acc_cnt !== 16'd0 || flush_done !== 1'b0) begin
      errors++;
      $display("FAIL areset got v=%h cnt=%0d fd=%b exp 0/0/0",
               out_valid, acc_cnt, flush_done);
    end
    m_reset();
    tick();
    rst = 1'b0;
    in_valid = 1'b1;
    in_data = 8'hE1;
    #1;
    tick();
    checks++;
    if (sel !== 2'd0 || out_valid !== 4'b0001 || out_data[7:0] !== 8'hE1) begin
      errors++;
      $display("FAIL areset_first got sel=%0d v=%h d0=%h exp 0/1/e1",
               sel, out_valid, out_data[7:0]);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      mode = 1'($urandom_range(0, 1));
      in_valid = ($urandom_range(0, 3) != 0);
      in_data = 8'($urandom);
      in_dest = 2'($urandom);
      out_ready = 4'($urandom);
      if ($urandom_range(0, 39) == 0) flush_req = !flush_req;
      #1;
      checks++;
      if (in_ready !== m_ready()) begin
        errors++;
        $display("FAIL rand_ready[%0d] got %b exp %b", n, in_ready, m_ready());
      end
      checks++;
      if (out_valid !== m_v || out_data !== m_data()) begin
        errors++;
        $display("FAIL rand_slots[%0d] got v=%h d=%h exp %h/%h",
                 n, out_valid, out_data, m_v, m_data());
      end
      checks++;
      if (sel !== 2'(m_sel) || acc_cnt !== 16'(m_cnt) || flush_done !== m_done) begin
        errors++;
        $display("FAIL rand_regs[%0d] got sel=%0d cnt=%0d fd=%b exp %0d/%0d/%b",
                 n, sel, acc_cnt, flush_done, m_sel, m_cnt, m_done);
      end
      tick();
    end
    flush_req = 1'b0;
    in_valid = 1'b0;
    out_ready = 4'hF;
    repeat (4) tick();
  endtask

  task automatic test_wrap();
    rst = 1'b1;
    m_reset();
    tick();
    rst = 1'b0;
    mode = 1'b0;
    flush_req = 1'b0;
    out_ready = 4'hF;
    in_valid = 1'b1;
    for (int n = 0; n < 65535; n++) begin
      in_data = n[7:0];
      tick();
    end
    checks++;
    if (acc_cnt !== 16'hFFFF || acc_cnt !== 16'(m_cnt)) begin
      errors++;
      $display("FAIL wrap_ffff got %h exp ffff", acc_cnt);
    end
    tick();
    checks++;
    if (acc_cnt !== 16'h0000 || acc_cnt !== 16'(m_cnt)) begin
      errors++;
      $display("FAIL wrap_zero got %h exp 0000", acc_cnt);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rr_fill();
    test_skip_occupied();
    test_directed();
    test_flush();
    test_async_reset();
    test_random();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
